// File: rtl/cmp_iter.sv
// cmp_iter: multi-cycle branch/magnitude comparator for the MIPS pipeline.
// Walks the operands one SLICE-bit slice per cycle, most-significant slice first.
module cmp_iter #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             cmp
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_eq_acc;
  logic             r_az_acc;
  logic             r_bz_acc;
  logic             r_dec;
  logic             r_lt_acc;
  logic             r_sign_a;
  logic             r_busy;
  logic             r_done;
  logic             r_cmp;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_a_mag;
  logic [SLICE-1:0] w_b_mag;
  logic             w_signed_step;
  logic             w_diff;
  logic             w_eq_n;
  logic             w_az_n;
  logic             w_bz_n;
  logic             w_dec_n;
  logic             w_lt_n;

  function automatic logic f_result(input logic [3:0] fop, input logic eq, input logic az,
                                    input logic bz, input logic lt, input logic sa);
    logic res;
    case (fop)
      4'd0:    res = eq;
      4'd1:    res = ~eq;
      4'd2:    res = ~sa & ~az;
      4'd3:    res = ~sa;
      4'd4:    res = sa;
      4'd5:    res = sa | az;
      4'd6:    res = bz;
      4'd7:    res = ~bz;
      4'd8:    res = lt;
      4'd9:    res = ~lt;
      4'd10:   res = lt;
      4'd11:   res = ~lt;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Slice step: the operand copies shift left, so the current slice is always on top.
  always_comb begin
    w_a_sl        = r_a[WIDTH-1 -: SLICE];
    w_b_sl        = r_b[WIDTH-1 -: SLICE];
    w_signed_step = (r_cnt == CW'(0)) && ((r_op == 4'd8) || (r_op == 4'd9));
    w_a_mag       = w_a_sl;
    w_b_mag       = w_b_sl;
    // Flipping both sign bits turns the signed top slice into an unsigned compare.
    if (w_signed_step) begin
      w_a_mag[SLICE-1] = ~w_a_sl[SLICE-1];
      w_b_mag[SLICE-1] = ~w_b_sl[SLICE-1];
    end else begin
      w_a_mag = w_a_sl;
      w_b_mag = w_b_sl;
    end
    w_diff  = (w_a_sl != w_b_sl);
    w_eq_n  = r_eq_acc & ~w_diff;
    w_az_n  = r_az_acc & (w_a_sl == {SLICE{1'b0}});
    w_bz_n  = r_bz_acc & (w_b_sl == {SLICE{1'b0}});
    w_dec_n = r_dec | w_diff;
    if (!r_dec && w_diff) begin
      w_lt_n = (w_a_mag < w_b_mag);
    end else begin
      w_lt_n = r_lt_acc;
    end
  end

  // Control FSM, accumulators and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_op     <= 4'd0;
      r_cnt    <= CW'(0);
      r_eq_acc <= 1'b1;
      r_az_acc <= 1'b1;
      r_bz_acc <= 1'b1;
      r_dec    <= 1'b0;
      r_lt_acc <= 1'b0;
      r_sign_a <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cmp    <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_op     <= op;
            r_sign_a <= A[WIDTH-1];
            r_cnt    <= CW'(0);
            r_eq_acc <= 1'b1;
            r_az_acc <= 1'b1;
            r_bz_acc <= 1'b1;
            r_dec    <= 1'b0;
            r_lt_acc <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_BUSY;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_a      <= r_a << SLICE;
          r_b      <= r_b << SLICE;
          r_cnt    <= r_cnt + CW'(1);
          r_eq_acc <= w_eq_n;
          r_az_acc <= w_az_n;
          r_bz_acc <= w_bz_n;
          r_dec    <= w_dec_n;
          r_lt_acc <= w_lt_n;
          if (r_cnt == CW'(N - 1)) begin
            r_cmp   <= f_result(r_op, w_eq_n, w_az_n, w_bz_n, w_dec_n & w_lt_n, r_sign_a);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign cmp  = r_cmp;

endmodule

// File: tb/tb_cmp_iter.sv
// Self-checking bench for cmp_iter: three parameterisations driven in parallel,
// a cycle-level reference model and directed vectors with literal expectations.
module tb_cmp_iter;

  localparam int NI = 3;
  localparam int MW [NI] = '{32, 16, 64};
  localparam int MN [NI] = '{4, 1, 16};

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          start   = 1'b0;
  logic          flush   = 1'b0;
  logic [3:0]    op      = 4'd0;
  logic [63:0]   A       = 64'd0;
  logic [63:0]   B       = 64'd0;
  logic [NI-1:0] busy;
  logic [NI-1:0] done;
  logic [NI-1:0] cmp;

  int n_checks = 0;
  int n_fail   = 0;
  int ndone [NI];
  int nbusy [NI];
  bit chk_en   = 1'b0;

  int   rem    [NI];
  logic m_busy [NI];
  logic m_done [NI];
  logic m_cmp  [NI];
  logic m_pend [NI];

  always #5 clk = ~clk;

  cmp_iter #(.WIDTH(32), .SLICE(8)) u_w32 (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .op(op),
    .A(A[31:0]), .B(B[31:0]), .busy(busy[0]), .done(done[0]), .cmp(cmp[0]));

  cmp_iter #(.WIDTH(16), .SLICE(16)) u_w16 (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .op(op),
    .A(A[15:0]), .B(B[15:0]), .busy(busy[1]), .done(done[1]), .cmp(cmp[1]));

  cmp_iter #(.WIDTH(64), .SLICE(4)) u_w64 (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .op(op),
    .A(A), .B(B), .busy(busy[2]), .done(done[2]), .cmp(cmp[2]));

  // Reference result straight from the operation table, using native arithmetic.
  function automatic logic model_res(input logic [3:0] o, input logic [63:0] a,
                                     input logic [63:0] b, input int w);
    logic [63:0] mask, au, bu;
    longint sa, sb;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    au = a & mask;
    bu = b & mask;
    sa = $signed(au << (64 - w)) >>> (64 - w);
    sb = $signed(bu << (64 - w)) >>> (64 - w);
    case (o)
      4'd0:    return au == bu;
      4'd1:    return au != bu;
      4'd2:    return sa > 0;
      4'd3:    return sa >= 0;
      4'd4:    return sa < 0;
      4'd5:    return sa <= 0;
      4'd6:    return bu == 64'd0;
      4'd7:    return bu != 64'd0;
      4'd8:    return sa < sb;
      4'd9:    return sa >= sb;
      4'd10:   return au < bu;
      4'd11:   return au >= bu;
      default: return 1'b0;
    endcase
  endfunction

  // Timing model: a start accepted when not busy yields done N edges later.
  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset_n) begin
        rem[i] <= 0; m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_cmp[i] <= 1'b0;
      end else if (flush) begin
        rem[i] <= 0; m_busy[i] <= 1'b0; m_done[i] <= 1'b0;
      end else if (rem[i] > 1) begin
        rem[i] <= rem[i] - 1;
      end else if (rem[i] == 1) begin
        rem[i] <= 0; m_busy[i] <= 1'b0; m_done[i] <= 1'b1; m_cmp[i] <= m_pend[i];
      end else begin
        m_done[i] <= 1'b0;
        if (start) begin
          m_pend[i] <= model_res(op, A, B, MW[i]);
          rem[i]    <= MN[i];
          m_busy[i] <= 1'b1;
        end else begin
          m_busy[i] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0b required %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic go(input int id, input logic [3:0] o, input logic [63:0] a,
                    input logic [63:0] b, input logic [NI-1:0] e);
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = {$urandom, $urandom}; B = {$urandom, $urandom}; op = 4'($urandom);
    repeat (18) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("v%0d_dut%0d", id, i), cmp[i], e[i]);
      check($sformatf("v%0d_model%0d", id, i), m_cmp[i], e[i]);
    end
  endtask

  initial begin
    int d0;
    int b0 [NI];
    for (int i = 0; i < NI; i++) begin
      ndone[i] = 0;
      nbusy[i] = 0;
    end
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          for (int i = 0; i < NI; i++) begin
            check($sformatf("busy%0d", i), busy[i], m_busy[i]);
            check($sformatf("done%0d", i), done[i], m_done[i]);
            check($sformatf("cmp%0d", i), cmp[i], m_cmp[i]);
            if (done[i] === 1'b1) ndone[i]++;
            if (busy[i] === 1'b1) nbusy[i]++;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_busy%0d", i), busy[i], 1'b0);
      check($sformatf("rst_done%0d", i), done[i], 1'b0);
      check($sformatf("rst_cmp%0d", i), cmp[i], 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NI; i++) b0[i] = nbusy[i];
    go(1, 4'd0, 64'h00000000_12345678, 64'h00000000_12345678, 3'b111);
    for (int i = 0; i < NI; i++) check_int($sformatf("lat_busy%0d", i), nbusy[i] - b0[i], MN[i]);
    go(2, 4'd1, 64'h00000000_12345678, 64'h00000000_12345679, 3'b111);
    go(3, 4'd8, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000001, 3'b111);
    go(4, 4'd10, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000001, 3'b000);
    go(5, 4'd11, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000001, 3'b111);
    go(6, 4'd8, 64'h80000000_80000000, 64'h7FFFFFFF_7FFFFFFF, 3'b101);
    go(7, 4'd9, 64'h80000000_80000000, 64'h7FFFFFFF_7FFFFFFF, 3'b010);
    go(8, 4'd5, 64'h80000000_80000000, 64'h0, 3'b111);
    go(9, 4'd2, 64'h80000000_80000000, 64'h0, 3'b000);
    go(10, 4'd2, 64'h0, 64'h0, 3'b000);
    go(11, 4'd3, 64'h0, 64'h0, 3'b111);
    go(12, 4'd6, 64'h12345678_9ABCDEF0, 64'h0, 3'b111);
    go(13, 4'd7, 64'h12345678_9ABCDEF0, 64'h0, 3'b000);
    go(14, 4'd13, 64'h0, 64'h0, 3'b000);
    go(15, 4'd2, 64'h00000001_00000001, 64'h0, 3'b111);
    go(16, 4'd4, 64'hFFFF0000_FFFF0000, 64'h0, 3'b101);
    go(17, 4'd10, 64'h00000001_00000002, 64'h00000002_00000001, 3'b100);

    // Flush in the second busy cycle: no done, previous result retained.
    go(18, 4'd0, 64'h5, 64'h5, 3'b111);
    d0 = ndone[0];
    @(negedge clk);
    op = 4'd0; A = 64'h1; B = 64'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy[0], 1'b0);
    repeat (18) @(negedge clk);
    check("flush_cmp_hold", cmp[0], 1'b1);
    check_int("flush_no_done", ndone[0] - d0, 0);

    // Stray start while busy.
    d0 = ndone[0];
    @(negedge clk);
    op = 4'd1; A = 64'h7; B = 64'h7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    check_int("stray_one_done", ndone[0] - d0, 1);
    check("stray_cmp", cmp[0], 1'b0);

    // Back-to-back: start held high through the done cycle.
    d0 = ndone[0];
    @(negedge clk);
    op = 4'd0; A = 64'h9; B = 64'h9; start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    check_int("b2b_dones", ndone[0] - d0, 2);
    check("b2b_cmp", cmp[0], 1'b1);

    // Start and flush together in IDLE.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 4'd1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    for (int i = 0; i < NI; i++) check($sformatf("sf_busy%0d", i), busy[i], 1'b0);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-compare.
    @(negedge clk);
    op = 4'd0; A = 64'h3; B = 64'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("arst_busy%0d", i), busy[i], 1'b0);
      check($sformatf("arst_done%0d", i), done[i], 1'b0);
      check($sformatf("arst_cmp%0d", i), cmp[i], 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    go(19, 4'd8, 64'h80000000_80000000, 64'h7FFFFFFF_7FFFFFFF, 3'b101);
    go(20, 4'd0, 64'h0000ABCD_0000ABCD, 64'h0000ABCD_0000ABCD, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
